// File: rtl/multi_cycle_controller.sv
// Multi-cycle ARM control unit: sequences each instruction through fetch/decode/execute/memory/writeback
// over a shared memory port, holds the NZCV flags and faults on illegal opcodes or stalled memory.
module multi_cycle_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5,
  parameter int ALU_CTRL_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr,
  input  logic [3:0]            alu_flags,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic [3:0]            state,
  output logic                  fault
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5, S_EXECR  = 4'd6, S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9, S_FAULT  = 4'd15
  } state_e;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4'd0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(4'd1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(4'd2);
  localparam logic [ALU_CTRL_W-1:0] ALU_ORR = ALU_CTRL_W'(4'd3);
  localparam logic [ALU_CTRL_W-1:0] ALU_MOV = ALU_CTRL_W'(4'd4);
  localparam logic [3:0]            CMD_CMP = 4'b1010;

  localparam logic             WDOG_EN  = (TIMEOUT_CYCLES != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  function automatic logic cmd_legal(input logic [3:0] cmd);
    case (cmd)
      4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1101: cmd_legal = 1'b1;
      default: cmd_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [ALU_CTRL_W-1:0] cmd_alu(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: cmd_alu = ALU_SUB;
      4'b0000:          cmd_alu = ALU_AND;
      4'b1100:          cmd_alu = ALU_ORR;
      4'b1101:          cmd_alu = ALU_MOV;
      default:          cmd_alu = ALU_ADD;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [1:0] op_s;
  logic [3:0] cmd_s;
  logic       l_bit_s, timeout_s, in_wait_s, unused_instr_s;

  assign op_s           = instr[27:26];
  assign cmd_s          = instr[24:21];
  assign l_bit_s        = instr[20];
  assign unused_instr_s = ^instr[19:0];
  assign in_wait_s      = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout_s      = WDOG_EN && (wait_cnt_q == TMO_LAST) && !mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      flags_q    <= 4'b0000;
      wait_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state, flag update and control outputs; reset forces every output low.
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    imm_src     = 2'b00;
    reg_src     = 2'b00;
    state       = 4'd0;
    fault       = 1'b0;
    if (reset) begin
      state_d = S_FETCH;
    end else begin
      state = state_q;
      if (state_q != S_FAULT) begin
        imm_src = op_s;
        reg_src = {(op_s == 2'b01) & ~l_bit_s, (op_s == 2'b10)};
      end else begin
        imm_src = 2'b00;
      end
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
          if (mem_ready)      state_d = S_DECODE;
          else if (timeout_s) state_d = S_FAULT;
          else                state_d = S_FETCH;
        end
        S_DECODE: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (!cond_pass(instr[31:28], flags_q)) state_d = S_FETCH;
          else if (op_s == 2'b11)                state_d = S_FAULT;
          else if (op_s == 2'b01)                state_d = S_MEMADR;
          else if (op_s == 2'b10)                state_d = S_BRANCH;
          else if (!cmd_legal(cmd_s))            state_d = S_FAULT;
          else if (instr[25])                    state_d = S_EXECI;
          else                                   state_d = S_EXECR;
        end
        S_MEMADR: begin
          alu_src_b = 2'b01;
          state_d   = l_bit_s ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready)      state_d = S_MEMWB;
          else if (timeout_s) state_d = S_FAULT;
          else                state_d = S_MEMRD;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          result_src = 2'b01;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (mem_ready)      state_d = S_FETCH;
          else if (timeout_s) state_d = S_FAULT;
          else                state_d = S_MEMWR;
        end
        S_EXECR, S_EXECI: begin
          alu_src_b   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
          alu_control = cmd_alu(cmd_s);
          state_d     = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = (cmd_s != CMD_CMP);
          if (l_bit_s || (cmd_s == CMD_CMP)) flags_d = alu_flags;
          else                               flags_d = flags_q;
          state_d = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_b  = 2'b01;
          result_src = 2'b10;
          pc_write   = 1'b1;
          state_d    = S_FETCH;
        end
        S_FAULT: begin
          fault   = 1'b1;
          state_d = S_FAULT;
        end
        default: state_d = S_FAULT;
      endcase
    end
  end

  // Memory wait counter: restarts on every state change, saturates while stalled.
  always_comb begin
    if (state_d != state_q)
      wait_cnt_d = {CNT_W{1'b0}};
    else if (in_wait_s && !mem_ready && (wait_cnt_q != CNT_MAX))
      wait_cnt_d = wait_cnt_q + CNT_ONE;
    else
      wait_cnt_d = wait_cnt_q;
  end

endmodule
